ahblite_irq_ctrl: RTL
=====================

Name: ahblite_irq_ctrl

Overview:
AHB-Lite slave interrupt controller that sits downstream of the timer and other peripherals. It consumes their interrupt outputs, for example the timer's single-cycle timer_irq pulse. It latches rising edges into a pending register, masks them with a software enable register and drives one CPU interrupt line plus the ID of the lowest-numbered active source. It sits on the same AHB-Lite matrix as the other peripherals: zero wait states, word access only.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32)

Ports:
HCLK  in  1  bus/system clock
HRESETn  in  1  async active-low reset
HSEL  in  1  slave select
HADDR  in  32  address; only HADDR[4:2] decoded
HTRANS  in  2  transfer type; HTRANS[1]=1 means active
HSIZE  in  3  ignored (word access only)
HPROT  in  4  ignored
HWRITE  in  1  1=write
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready
HREADYOUT  out  1  tied 1
HRDATA  out  32  read data (data phase)
HRESP  out  1  tied 0
irq_src  in  NUM_SRC  peripheral interrupt inputs, HCLK-synchronous; pulse or level
irq_out  out  1  registered interrupt to CPU
irq_id  out  6  {valid, index[4:0]} of lowest-index active source

Behaviour:
- Reset: HRESETn is asynchronous, active-low; clock is HCLK. On reset: pend=0, enable=0, src_d=0, addr_reg=0, rd/wr flags=0, irq_out=0, irq_id=0.
- Address phase: when HSEL & HREADY & HTRANS[1], register HADDR[4:2] into addr_reg and HWRITE into wr_en_reg; otherwise wr_en_reg=0.
- Data-phase write: commits on the edge where wr_en_reg & HREADY, using HWDATA[NUM_SRC-1:0].
- Register map:
  - 0x00 PEND: read returns pend. Write-1-to-clear.
  - 0x04 ENABLE: read/write.
  - 0x08 ACTIVE: read-only, pend & enable.
  - 0x0C ID: read-only, {26'b0, irq_id}.
  - 0x10 SWSET: write-only, write-1-to-set pend; reads 0.
  - Other offsets: reads 0, writes ignored.
- HRDATA: combinational from addr_reg and the current register state; unused upper bits are 0.
- Edge capture: src_d <= irq_src every cycle. rise = irq_src & ~src_d. pend[i] is set on the edge where rise[i]=1.
  - A source already high when reset is released sets pend on the first clock edge.
  - A held-high level sets pend only once.
- Next-pend priority per bit: set (rise or SWSET) beats W1C clear. A clear and a new edge in the same cycle leave pend=1, so no event is lost.
- pend is latched regardless of enable. Enabling a source later that is already pending raises irq_out.
- irq_out <= |(pend & enable), registered. Latency: irq_src rises before edge N, pend=1 after edge N, irq_out=1 after edge N+1.
- irq_id: registered in the same cycle as irq_out.
  - index = lowest i with pend[i]&enable[i]; valid=1 when any such i exists.
  - Otherwise irq_id=0.
- Clearing the last active pend bit drops irq_out one cycle after the write commits.
- NUM_SRC<32: upper HWDATA bits are ignored and read back as 0.
- Reset mid-operation: all state clears immediately and asynchronously. A source pulse coinciding with reset assertion is lost.

Optional Feature:
IRQ_SYNC_EN
- Defined: irq_src passes through a 2-flop synchroniser (reset 0) before edge detection, so irq_src may be asynchronous. Edge-to-pend latency grows by 2 cycles (pend after edge N+2, irq_out after N+3).
- Undefined: no synchroniser; irq_src must be HCLK-synchronous; latency as in Behaviour.

Test Plan:
- Single pulse: write ENABLE=0x01, pulse irq_src[0] for 1 cycle -> PEND reads 0x01; irq_out=1 two edges after the pulse; ID reads 0x20.
- Masked then enabled: ENABLE=0, pulse irq_src[3] -> PEND=0x08, irq_out stays 0. Then write ENABLE=0x08 -> irq_out=1 one cycle after the write commits; ID=0x23.
- Priority: ENABLE=0xFF, pulse sources 5 and 2 together -> ID=0x22. Write PEND=0x04 -> ID=0x25, irq_out stays 1. Write PEND=0x20 -> irq_out=0, ID=0.
- Clear/set collision: irq_src[1] rises in the same cycle that a W1C PEND=0x02 commits -> PEND still reads 0x02.
- Level hold and SWSET: hold irq_src[4] high for 10 cycles, clear PEND after 3 cycles -> PEND stays 0 until the next rising edge. Write SWSET=0x80 -> PEND bit7=1; reading SWSET returns 0.
- Reset mid-operation: with PEND=0xFF and irq_out=1, assert HRESETn low -> PEND, ENABLE, irq_out and irq_id all 0 immediately; unmapped offset 0x14 reads 0 after release.

Source files
------------

// File: rtl/ahblite_irq_ctrl.sv
// ---------------------------------------------------------------------------
// ahblite_irq_ctrl
//
// AHB-Lite slave interrupt controller. It captures rising edges of the
// peripheral interrupt inputs into a pending register and masks them with a
// software enable register. It drives one registered CPU interrupt line and
// the {valid, index} of the lowest-numbered active source. The controller has
// zero wait states and supports word access only.
//
// Register map (byte offsets, HADDR[4:2] decoded):
//   0x00 PEND    R/W1C  latched source edges
//   0x04 ENABLE  R/W    per-source mask
//   0x08 ACTIVE  RO     PEND & ENABLE
//   0x0C ID      RO     {26'b0, irq_id}
//   0x10 SWSET   WO     write-1-to-set PEND, reads 0
//   others              read 0, writes ignored
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL .. HREADY       AHB-Lite slave inputs (HSIZE/HPROT ignored)
//   HREADYOUT, HRESP     always ready, always OKAY
//   HRDATA               read data, combinational from the latched address
//   irq_src[NUM_SRC]     peripheral interrupt inputs (pulse or level)
//   irq_out              registered interrupt to the CPU
//   irq_id[5:0]          {valid, index[4:0]}, registered with irq_out
//
// Build option:
//   IRQ_SYNC_EN  when defined, irq_src passes through a 2-flop synchroniser
//                before edge detection, which adds 2 cycles of latency.
// ---------------------------------------------------------------------------
module ahblite_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HSIZE,
    input  logic [3:0]         HPROT,
    input  logic               HWRITE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic [31:0]        HRDATA,
    output logic               HRESP,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_out,
    output logic [5:0]         irq_id
);

    localparam logic [2:0] REG_PEND   = 3'd0;
    localparam logic [2:0] REG_ENABLE = 3'd1;
    localparam logic [2:0] REG_ACTIVE = 3'd2;
    localparam logic [2:0] REG_ID     = 3'd3;
    localparam logic [2:0] REG_SWSET  = 3'd4;

    logic [2:0]         addr_q,     addr_d;
    logic               wr_en_q,    wr_en_d;
    logic [NUM_SRC-1:0] pend_q,     pend_d;
    logic [NUM_SRC-1:0] enable_q,   enable_d;
    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic               irq_out_q,  irq_out_d;
    logic [5:0]         irq_id_q,   irq_id_d;

    logic [NUM_SRC-1:0] src_eff;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] sw_set;
    logic [NUM_SRC-1:0] sw_clr;
    logic               wr_commit;

    // Bus inputs that carry no information for a word-only, 8-register slave.
    logic unused_bits;
    assign unused_bits = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign irq_out   = irq_out_q;
    assign irq_id    = irq_id_q;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_eff = sync2_q;
`else
    assign src_eff = irq_src;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_commit  = wr_en_q & HREADY;
        wdata      = HWDATA[NUM_SRC-1:0];
        sw_clr     = '0;
        sw_set     = '0;
        enable_d   = enable_q;
        irq_id_d   = '0;

        // Address phase: latch the register select and direction.
        if (HSEL && HREADY && HTRANS[1]) begin
            addr_d  = HADDR[4:2];
            wr_en_d = HWRITE;
        end

        if (wr_commit) begin
            case (addr_q)
                REG_PEND:   sw_clr   = wdata;
                REG_ENABLE: enable_d = wdata;
                REG_SWSET:  sw_set   = wdata;
                default:    ;
            endcase
        end

        rise       = src_eff & ~src_prev_q;
        src_prev_d = src_eff;

        // Sets are ORed in after the clear so an edge arriving in the same
        // cycle as a W1C survives.
        pend_d = (pend_q & ~sw_clr) | rise | sw_set;

        active    = pend_q & enable_q;
        irq_out_d = |active;

        // Scan downwards so the lowest active index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_id_d = {1'b1, 5'(i)};
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            pend_q     <= '0;
            enable_q   <= '0;
            src_prev_q <= '0;
            irq_out_q  <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            pend_q     <= pend_d;
            enable_q   <= enable_d;
            src_prev_q <= src_prev_d;
            irq_out_q  <= irq_out_d;
            irq_id_q   <= irq_id_d;
        end
    end

    // Read mux: upper bits stay 0 for NUM_SRC < 32 and for SWSET/unmapped.
    always_comb begin
        HRDATA = '0;
        case (addr_q)
            REG_PEND:   HRDATA[NUM_SRC-1:0] = pend_q;
            REG_ENABLE: HRDATA[NUM_SRC-1:0] = enable_q;
            REG_ACTIVE: HRDATA[NUM_SRC-1:0] = active;
            REG_ID:     HRDATA[5:0]         = irq_id_q;
            default:    ;
        endcase
    end

endmodule
